// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package fp_mul_pkg;

  localparam int          N_REQ_DEF   = 4;
  localparam int          TIMEOUT_DEF = 16;
  localparam logic [31:0] QNAN_32     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_idx;

  // Walk the slots starting at ptr; N_REQ is a power of two so the add wraps for free.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ptr + IW'(i);
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP32 multiplier among N_REQ requesters, one operation in flight.
// Latency: accept at cycle 0, mul_start at 1, response the cycle after mul_done (or after TIMEOUT WAIT cycles).
// Backpressure: response held in RESP until rsp_ready; no new grant until the cycle after that handshake.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [32*N_REQ-1:0]      req_a,
  input  logic [32*N_REQ-1:0]      req_b,
  output logic                     mul_start,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic                     mul_done,
  input  logic [31:0]              mul_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_err;

  logic          w_gnt_valid;
  logic [IW-1:0] w_gnt_idx;
  logic [31:0]   w_sel_a;
  logic [31:0]   w_sel_b;
  logic          w_timeout;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // Timer sits at TIMEOUT-1 on the last allowed WAIT cycle; a done in that cycle still wins.
  assign w_timeout = (r_state == ST_WAIT) && (r_timer == TW'(TIMEOUT - 1));

  // Mux the granted slot's operands out of the packed request buses.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == IW'(i)) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_gnt_valid)            w_next = ST_ISSUE;
      ST_ISSUE:                             w_next = ST_WAIT;
      ST_WAIT:  if (mul_done || w_timeout)  w_next = ST_RESP;
      ST_RESP:  if (rsp_ready)              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  // Strobes; req_ready is gated by reset so nothing is accepted while it is asserted.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && w_gnt_valid && !reset) req_ready[w_gnt_idx] = 1'b1;
    mul_start = (r_state == ST_ISSUE);
    rsp_valid = (r_state == ST_RESP);
  end

  // Datapath: operand/grant capture, wait timer, response capture, pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_timer    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_grant <= w_gnt_idx;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
          end
        end
        ST_ISSUE: r_timer <= '0;
        ST_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (mul_done) begin
            r_rsp_data <= mul_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= QNAN_32;
            r_rsp_err  <= 1'b1;
          end
        end
        ST_RESP: if (rsp_ready) r_rr_ptr <= r_grant + IW'(1);
        default: ;
      endcase
    end
  end

  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign rsp_id   = r_grant;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed vector table, corner sequences, randomized run vs a reference model.
// Latency: n/a.
// Backpressure: rsp_ready is driven both held-low and randomly.
module tb_fp_mul_arbiter;

  localparam int          N    = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic           mul_start;
  logic [31:0]    mul_a;
  logic [31:0]    mul_b;
  logic           mul_done;
  logic [31:0]    mul_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;
  logic           rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ms_cnt = 0;
  int model_delay = 0;
  int stray_tok = 0;

  fp_mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Truncating FP32 multiply for normal operands whose product stays normal.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    logic [22:0] m;
    logic [7:0]  ev;
    int          e;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    ev = 8'(e);
    return {a[31] ^ b[31], ev, m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    ex = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Multiplier model: answers model_delay cycles after the start pulse (0 = never).
  initial begin
    int cd;
    int sseen;
    logic [31:0] la, lb;
    cd = 0; sseen = 0; la = '0; lb = '0;
    mul_done = 1'b0; mul_result = '0;
    forever begin
      @(posedge clk); #2;
      mul_done = 1'b0;
      if (reset) cd = 0;
      else if (stray_tok != sseen) begin
        sseen = stray_tok;
        mul_done = 1'b1;
        mul_result = 32'h1234_5678;
      end else if (mul_start) begin
        cd = model_delay; la = mul_a; lb = mul_b;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mul_done = 1'b1;
          mul_result = fp_mul(la, lb);
        end
      end
    end
  end

  // Count start pulses.
  initial forever begin
    @(posedge clk); #4;
    if (mul_start) ms_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b);
    req_a[32*s +: 32] = a;
    req_b[32*s +: 32] = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    chk({tag, "_mul_a"}, mul_a, 32'd0);
    chk({tag, "_mul_b"}, mul_b, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1; req_valid = '1; rsp_ready = 1'b0; settle();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick(); tick(); reset = 1'b0; req_valid = '0; settle();
  endtask

  typedef struct {
    int          slot;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    int          hold;
    int          lat;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int ms0, t0, waited;
    logic [N-1:0] oh;
    oh = '0;
    oh[v.slot] = 1'b1;
    ms0 = ms_cnt;
    tick();
    model_delay = v.delay; req_valid = oh; set_slot(v.slot, v.a, v.b);
    rsp_ready = (v.hold == 0);
    settle();
    waited = 0;
    while (req_ready == '0 && waited < 8) begin tick(); settle(); waited++; end
    chk("vec_accept", 32'(req_ready), 32'(oh));
    t0 = cyc;
    tick(); req_valid = '0; settle();
    chk("vec_start", 32'(mul_start), 32'd1);
    chk("vec_mul_a", mul_a, v.a);
    chk("vec_mul_b", mul_b, v.b);
    waited = 0;
    while (!rsp_valid && waited < 40) begin tick(); settle(); waited++; end
    chk("vec_rsp_latency", 32'(cyc - t0), 32'(v.lat));
    chk("vec_rsp_id", 32'(rsp_id), 32'(v.slot));
    chk("vec_rsp_data", rsp_data, v.exp_data);
    chk("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        tick(); req_valid = '1; settle();
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp_data", rsp_data, v.exp_data);
        chk("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("hold_rsp_id", 32'(rsp_id), 32'(v.slot));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_mul_start", 32'(mul_start), 32'd0);
      end
      tick(); req_valid = '0; rsp_ready = 1'b1; settle();
    end
    tick(); rsp_ready = 1'b0; settle();
    chk("vec_after_hs_valid", 32'(rsp_valid), 32'd0);
    chk("vec_start_count", 32'(ms_cnt - ms0), 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  vec_t vecs[6];
  int   exp_order[6] = '{0, 1, 2, 3, 0, 1};
  op_t  slot_q[N][$];
  rsp_t exp_q[$];

  initial begin
    int gidx[6];
    int gcyc[6];
    int gcount, multi, waited, remaining, ref_ptr, s, gs;
    bit ref_busy;
    logic [N-1:0] vld, exp_rdy;
    op_t  op;
    rsp_t r;

    vecs[0] = '{2, 32'h3FC0_0000, 32'h4000_0000,  3, 0,  5, 32'h4040_0000, 1'b0};
    vecs[1] = '{1, 32'h4040_0000, 32'h4080_0000,  1, 5,  3, 32'h4140_0000, 1'b0};
    vecs[2] = '{3, 32'h3F80_0000, 32'hC000_0000,  0, 0, 18, QNAN,          1'b1};
    vecs[3] = '{0, 32'h40A0_0000, 32'h3F00_0000, 16, 0, 18, 32'h4020_0000, 1'b0};
    vecs[4] = '{1, 32'h3F80_0000, 32'h3F80_0000, 17, 2, 18, QNAN,          1'b1};
    vecs[5] = '{2, 32'h4000_0000, 32'h4000_0000,  5, 0,  7, 32'h4080_0000, 1'b0};

    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    do_reset();
    chk_zero("reset");

    // All four requesters continuously valid: strict rotation, one grant every 4 cycles.
    tick();
    model_delay = 1; rsp_ready = 1'b1; req_valid = '1;
    for (int i = 0; i < N; i++) set_slot(i, rand_fp(), rand_fp());
    settle();
    gcount = 0; multi = 0;
    for (int k = 0; k < 100 && gcount < 6; k++) begin
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != '0) begin
        gidx[gcount] = idx_of(req_ready);
        gcyc[gcount] = cyc;
        gcount++;
      end
      tick(); settle();
    end
    chk("rr_grant_count", 32'(gcount), 32'd6);
    for (int i = 0; i < 6; i++) chk("rr_grant_order", 32'(gidx[i]), 32'(exp_order[i]));
    for (int i = 1; i < 6; i++) chk("rr_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
    chk("rr_multi_ready", 32'(multi), 32'd0);
    tick(); req_valid = '0;
    repeat (8) tick();
    rsp_ready = 1'b0;

    // Directed single-request table.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while WAITing, then a stray mul_done; next grant restarts from slot 0.
    tick(); model_delay = 0; req_valid = 4'b0010; set_slot(1, 32'h3F80_0000, 32'h3F80_0000); settle();
    waited = 0;
    while (req_ready == '0 && waited < 8) begin tick(); settle(); waited++; end
    chk("midrst_accept", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; settle();
    repeat (3) tick();
    reset = 1'b1; settle();
    chk_zero("midrst_in");
    tick(); tick(); reset = 1'b0; settle();
    chk_zero("midrst_out");
    tick(); stray_tok++; settle();
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(); settle();
    chk("stray_rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("stray_mul_start", 32'(mul_start), 32'd0);
    tick(); model_delay = 2; rsp_ready = 1'b1; req_valid = 4'b1001; settle();
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    repeat (8) tick();
    rsp_ready = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    remaining = 0;
    for (int i = 0; i < 24; i++) begin
      op.a = rand_fp(); op.b = rand_fp(); op.delay = $urandom_range(0, 20);
      slot_q[$urandom_range(0, N-1)].push_back(op);
      remaining++;
    end
    vld = '0; ref_ptr = 0; ref_busy = 1'b0;
    for (int c = 0; c < 4000 && remaining > 0; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && slot_q[i].size() > 0 && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          set_slot(i, slot_q[i][0].a, slot_q[i][0].b);
        end else if (!vld[i]) begin
          set_slot(i, $urandom, $urandom);
        end
      end
      req_valid = vld;
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      exp_rdy = '0; gs = -1;
      if (!ref_busy) begin
        for (int k = 0; k < N && gs < 0; k++) begin
          s = (ref_ptr + k) % N;
          if (vld[s]) gs = s;
        end
        if (gs >= 0) exp_rdy[gs] = 1'b1;
      end
      if (vld != '0 || req_ready != '0) chk("rand_grant", 32'(req_ready), 32'(exp_rdy));
      if (gs >= 0) begin
        op = slot_q[gs].pop_front();
        vld[gs] = 1'b0;
        model_delay = op.delay;
        ref_busy = 1'b1;
        r.id   = gs;
        r.err  = (op.delay == 0 || op.delay > TO);
        r.data = r.err ? QNAN : fp_mul(op.a, op.b);
        exp_q.push_back(r);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rand_spurious_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
        end else begin
          r = exp_q.pop_front();
          chk("rand_rsp_id", 32'(rsp_id), 32'(r.id));
          chk("rand_rsp_data", rsp_data, r.data);
          chk("rand_rsp_err", 32'(rsp_err), 32'(r.err));
          ref_ptr = (r.id + 1) % N;
        end
        ref_busy = 1'b0;
        remaining--;
      end
    end
    chk("rand_drained", 32'(remaining), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one FP32 multiplier; power of two, 2..8.
REQ-002 Parameter TIMEOUT, 16, maximum WAIT cycles before the multiplier is declared hung.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  one-hot accept strobe; operands are taken on the cycle it is high.
REQ-007 req_a, req_b  input  32*N_REQ  packed operands; slot i is at [32i+31:32i].
REQ-008 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-009 mul_a, mul_b  output  32  latched operands, held stable from ISSUE through WAIT.
REQ-010 mul_done  input  1  multiplier completion pulse.
REQ-011 mul_result  input  32  multiplier product, valid with mul_done.
REQ-012 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-013 rsp_id  output  log2(N_REQ)  index of the requester being answered.
REQ-014 rsp_data  output  32  product, or qNaN on timeout.
REQ-015 rsp_err  output  1  high when the response was produced by timeout.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP and SHALL hold exactly one operation in flight.
REQ-017 IDLE: if any req_valid is high, the arbiter SHALL grant the first set bit at or after rr_ptr, wrapping modulo N_REQ; pulse req_ready[grant]; latch req_a/req_b[grant] and grant; then move to ISSUE.
REQ-018 req_ready SHALL be all zero in every cycle other than a granting IDLE cycle.
REQ-019 ISSUE: mul_start SHALL be 1 for exactly one cycle, the WAIT timer SHALL clear, and the FSM SHALL go to WAIT.
REQ-020 WAIT: the timer SHALL increment each cycle; mul_done=1 SHALL capture mul_result into rsp_data with rsp_err=0 and move to RESP.
REQ-021 WAIT: if the timer reaches TIMEOUT-1 without mul_done, the FSM SHALL load rsp_data=0x7FC00000, set rsp_err=1 and move to RESP.
REQ-022 If mul_done and timeout occur in the same cycle, mul_done SHALL take priority (rsp_err=0).
REQ-023 mul_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-024 RESP: rsp_valid=1; rsp_id, rsp_data and rsp_err SHALL be held stable until rsp_ready=1. On that handshake the FSM SHALL set rr_ptr=(grant+1) mod N_REQ and return to IDLE.
REQ-025 Latency: with accept at cycle 0, mul_start SHALL be high at cycle 1, and rsp_valid SHALL rise one cycle after the accepted mul_done.
REQ-026 A new request SHALL be granted no earlier than the cycle after the response handshake.

Reset
REQ-027 Reset SHALL force state IDLE, rr_ptr=0, timer=0, and all outputs to 0, including rsp_data.
REQ-028 Reset mid-operation SHALL discard the in-flight operation without a response; the requester SHALL re-present it.

Structure
REQ-029 Shared package fp_mul_pkg SHALL hold the state enum, the QNAN_32=0x7FC00000 constant, and the N_REQ/TIMEOUT defaults.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter with inputs req and ptr and outputs gnt_valid and gnt_idx.

Verification
REQ-031 Single request on slot 2 with a=0x3FC00000 and b=0x40000000; the model answers 0x40400000 three cycles after start -> rsp_id=2, rsp_data=0x40400000, rsp_err=0, and mul_start pulses exactly once.
REQ-032 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; at most one req_ready high per cycle.
REQ-033 rsp_ready held low for 5 cycles in RESP -> rsp_valid and its data stay stable, no req_ready, and no mul_start.
REQ-034 Model never asserts done, TIMEOUT=16 -> after 16 WAIT cycles rsp_err=1 and rsp_data=0x7FC00000.
REQ-035 Reset asserted in WAIT, then a stray mul_done after release -> all outputs 0, no rsp_valid, and the next grant goes to slot 0 when slots 0 and 3 are both valid.
